uart_rx_deserializer: RTL and testbench

- Functional UART receive path: recovers frames from asynchronous serial input `rx_in` and delivers bytes plus error flags to the register block.
- Consumes the same config fields as the transmitter (baud_divisor, data_bits, stop_bits, parity_config) with identical encodings, so TX→RX loopback is bit-exact.
- Holds one received byte until the register block acknowledges it with `data_ack`.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_sampler.sv | 50 +++++
 rtl/uart_rx_deserializer.sv | 200 ++++++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, parity encodings, divisor
// floor and the register map used by the register block.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;

  // Smallest usable bit period minus one; smaller divisors are clamped up.
  localparam int MIN_DIV = 3;

  // Register addresses (byte offsets) shared with the register block.
  localparam logic [7:0] REG_TX_DATA = 8'h00;
  localparam logic [7:0] REG_RX_DATA = 8'h04;
  localparam logic [7:0] REG_STATUS  = 8'h08;
  localparam logic [7:0] REG_CONFIG  = 8'h0C;
  localparam logic [7:0] REG_BAUD    = 8'h10;

endpackage

// File: rtl/uart_rx_sampler.sv
// rx_in front end: synchronizer, falling-edge detect and, when
// UART_RX_MAJORITY_VOTE_EN is defined, a 2-of-3 majority vote.
//   clk, rst_n : clock, async active-low reset
//   rx_in      : raw serial input (idle high)
//   rx_s       : synchronized line (last synchronizer stage)
//   fall       : rx_s went 1 -> 0 this cycle
//   rx_vote    : (vote build only) majority of rx_s over the last 3 cycles
module uart_rx_sampler #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_in,
  output logic rx_s,
`ifdef UART_RX_MAJORITY_VOTE_EN
  output logic rx_vote,
`endif
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
      prev_q <= rx_s;
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign fall = prev_q & ~rx_s;

`ifdef UART_RX_MAJORITY_VOTE_EN
  // Vote over cnt-1, cnt, cnt+1: evaluated at cnt+1, so rx_s is the late
  // sample and the two flops hold the nominal and early samples.
  logic prev2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev2_q <= 1'b1;
    else        prev2_q <= prev_q;
  end

  assign rx_vote = (rx_s & prev_q) | (rx_s & prev2_q) | (prev_q & prev2_q);
`endif

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive path: recovers start/data/parity/stop frames from rx_in and
// holds one byte plus error flags until the register block acks it.
// Optional build macro: UART_RX_MAJORITY_VOTE_EN (2-of-3 vote per sample,
// decisions land one clock after the nominal point).
//   clk, rst_n     : clock, async active-low reset
//   enable         : receiver enable; low aborts any frame in flight
//   baud_divisor   : bit period = divisor+1 clocks (floor MIN_DIV)
//   data_bits      : data bits minus 1; stop_bits: 0=1, 1=2 stop bits
//   parity_config  : 00 none, 01 odd, 1x even
//   rx_in          : serial input, idle high
//   data_out/data_valid/data_ack : held byte, level valid, consume strobe
//   parity_err/frame_err/overrun_err : flags belonging to the held byte
//   busy           : a frame is being received
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DIV_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] baud_divisor,
  input  logic [2:0]       data_bits,
  input  logic             stop_bits,
  input  logic [1:0]       parity_config,
  input  logic             rx_in,
  output logic [7:0]       data_out,
  output logic             data_valid,
  input  logic             data_ack,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun_err,
  output logic             busy
);

  logic rx_s, fall, smp;

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic rx_vote;
  // Decision taken one clock late; the counter restarts at 1 so the late
  // offset does not accumulate across bits.
  localparam logic [DIV_W-1:0] SOFF = DIV_W'(1);
  uart_rx_sampler #(.SYNC_STAGES(SYNC_STAGES)) u_smp (
    .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .rx_s(rx_s), .rx_vote(rx_vote), .fall(fall)
  );
  assign smp = rx_vote;
`else
  localparam logic [DIV_W-1:0] SOFF = '0;
  uart_rx_sampler #(.SYNC_STAGES(SYNC_STAGES)) u_smp (
    .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .rx_s(rx_s), .fall(fall)
  );
  assign smp = rx_s;
`endif

  rx_state_e        state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d;
  logic [2:0]       bit_idx_q, bit_idx_d, db_q, db_d;
  logic             sb_q, sb_d, stop2_q, stop2_d;
  logic [1:0]       par_q, par_d;
  logic [7:0]       shift_q, shift_d;
  logic             pe_pend_q, pe_pend_d, fe_pend_q, fe_pend_d;
  logic             done;

  logic [7:0]       data_out_q;
  logic             valid_q, pe_q, fe_q, oe_q;

  logic [DIV_W-1:0] d_eff, half_t, bit_t;
  logic             par_exp;

  assign d_eff   = (baud_divisor < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : baud_divisor;
  assign half_t  = (div_q >> 1) + SOFF;
  assign bit_t   = div_q + SOFF;
  // Unused upper shift bits are cleared at frame start, so a full XOR works.
  assign par_exp = (^shift_q) ^ (par_q == PAR_ODD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      div_q     <= DIV_W'(MIN_DIV);
      db_q      <= 3'd7;
      sb_q      <= 1'b0;
      par_q     <= PAR_NONE;
      bit_idx_q <= '0;
      shift_q   <= '0;
      pe_pend_q <= 1'b0;
      fe_pend_q <= 1'b0;
      stop2_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      db_q      <= db_d;
      sb_q      <= sb_d;
      par_q     <= par_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      pe_pend_q <= pe_pend_d;
      fe_pend_q <= fe_pend_d;
      stop2_q   <= stop2_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + DIV_W'(1);
    div_d     = div_q;
    db_d      = db_q;
    sb_d      = sb_q;
    par_d     = par_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pe_pend_d = pe_pend_q;
    fe_pend_d = fe_pend_q;
    stop2_d   = stop2_q;
    done      = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (enable && fall) begin
          // Frame config is captured here so mid-frame writes can't corrupt it.
          div_d     = d_eff;
          db_d      = data_bits;
          sb_d      = stop_bits;
          par_d     = parity_config;
          shift_d   = '0;
          pe_pend_d = 1'b0;
          fe_pend_d = 1'b0;
          stop2_d   = 1'b0;
          state_d   = RX_START;
        end
      end
      RX_START: if (cnt_q == half_t) begin
        if (smp) state_d = RX_IDLE;  // glitch, not a start bit
        else begin
          cnt_d     = SOFF;
          bit_idx_d = '0;
          state_d   = RX_DATA;
        end
      end
      RX_DATA: if (cnt_q == bit_t) begin
        cnt_d            = SOFF;
        shift_d[bit_idx_q] = smp;
        if (bit_idx_q == db_q) state_d = (par_q != PAR_NONE) ? RX_PARITY : RX_STOP;
        else                   bit_idx_d = bit_idx_q + 3'd1;
      end
      RX_PARITY: if (cnt_q == bit_t) begin
        cnt_d = SOFF;
        if (smp != par_exp) pe_pend_d = 1'b1;
        state_d = RX_STOP;
      end
      RX_STOP: if (cnt_q == bit_t) begin
        cnt_d = SOFF;
        if (!smp) fe_pend_d = 1'b1;
        if (sb_q && !stop2_q) stop2_d = 1'b1;
        else begin
          // Back to IDLE mid-stop-bit so a back-to-back start edge is caught.
          done    = 1'b1;
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
    if (!enable) begin
      state_d = RX_IDLE;
      cnt_d   = '0;
      done    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
      valid_q    <= 1'b0;
      pe_q       <= 1'b0;
      fe_q       <= 1'b0;
      oe_q       <= 1'b0;
    end else if (done) begin
      data_out_q <= shift_d;
      valid_q    <= 1'b1;
      pe_q       <= pe_pend_d;
      fe_q       <= fe_pend_d;
      oe_q       <= valid_q & ~data_ack;  // an ack this cycle frees the slot
    end else if (data_ack && valid_q) begin
      valid_q <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      oe_q    <= 1'b0;
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = valid_q;
  assign parity_err  = pe_q;
  assign frame_err   = fe_q;
  assign overrun_err = oe_q;
  assign busy        = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: directed frames, a frame-level model that
// predicts the held byte/flags and completion cycle, and a per-cycle compare.
module tb_uart_rx_deserializer;
  localparam int DIV_W = 16;
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int MV = 1;
`else
  localparam int MV = 0;
`endif

  logic             clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
  logic [DIV_W-1:0] baud_divisor = 16'd3;
  logic [2:0]       data_bits = 3'd7;
  logic             stop_bits = 1'b0;
  logic [1:0]       parity_config = 2'b00;
  logic             rx_in = 1'b1, data_ack = 1'b0;
  logic [7:0]       data_out;
  logic             data_valid, parity_err, frame_err, overrun_err, busy;

  int total = 0, bad = 0, cyc = 0, last_comp = 0;

  typedef struct {
    int         comp;
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] m_d  = '0;
  logic       m_v  = 1'b0, m_pe = 1'b0, m_fe = 1'b0, m_oe = 1'b0;

  always #5 clk = ~clk;

  uart_rx_deserializer #(.SYNC_STAGES(2), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .baud_divisor(baud_divisor),
    .data_bits(data_bits), .stop_bits(stop_bits), .parity_config(parity_config),
    .rx_in(rx_in), .data_out(data_out), .data_valid(data_valid), .data_ack(data_ack),
    .parity_err(parity_err), .frame_err(frame_err), .overrun_err(overrun_err), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cyc %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  // Holding-register model: a frame lands on its predicted edge, otherwise an
  // ack of a held byte empties the slot.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_v <= 1'b0; m_d <= '0; m_pe <= 1'b0; m_fe <= 1'b0; m_oe <= 1'b0;
      exp_q.delete();
    end else begin
      cyc <= cyc + 1;
      if (exp_q.size() > 0 && exp_q[0].comp == cyc + 1) begin
        m_oe <= m_v && !data_ack;
        m_v  <= 1'b1;
        m_d  <= exp_q[0].d;
        m_pe <= exp_q[0].pe;
        m_fe <= exp_q[0].fe;
        void'(exp_q.pop_front());
      end else if (data_ack && m_v) begin
        m_v <= 1'b0; m_pe <= 1'b0; m_fe <= 1'b0; m_oe <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("data_valid", {31'd0, data_valid}, {31'd0, m_v});
    chk("data_out", {24'd0, data_out}, {24'd0, m_d});
    chk("parity_err", {31'd0, parity_err}, {31'd0, m_pe});
    chk("frame_err", {31'd0, frame_err}, {31'd0, m_fe});
    chk("overrun_err", {31'd0, overrun_err}, {31'd0, m_oe});
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ack_pulse();
    data_ack = 1'b1;
    idle(1);
    data_ack = 1'b0;
  endtask

  // Sends one frame with the current config. par_bit<0 sends the correct
  // parity bit. Frame bit k is sampled k*(D+1)+HALF+1 clocks after the start
  // edge is driven; the held byte updates on edge E0+4+HALF+L*(D+1).
  task automatic send(input logic [7:0] d, input int par_bit, input logic stop2v,
                      input bit expect_it);
    int         dv, half, nb, nlen;
    logic       hasp, ep, pb;
    logic [7:0] m;
    logic       q[$];
    exp_t       e;
    dv   = (baud_divisor < 3) ? 3 : int'(baud_divisor);
    half = dv / 2;
    nb   = int'(data_bits) + 1;
    hasp = (parity_config != 2'b00);
    m    = '0;
    for (int i = 0; i < nb; i++) m[i] = d[i];
    ep   = (^m) ^ (parity_config == 2'b01);
    pb   = (par_bit < 0) ? ep : par_bit[0];
    q.push_back(1'b0);
    for (int i = 0; i < nb; i++) q.push_back(m[i]);
    if (hasp) q.push_back(pb);
    q.push_back(1'b1);
    if (stop_bits) q.push_back(stop2v);
    nlen = q.size() - 1;
    last_comp = cyc + 4 + half + nlen * (dv + 1) + MV;
    if (expect_it) begin
      e.comp = last_comp;
      e.d    = m;
      e.pe   = hasp && (pb != ep);
      e.fe   = stop_bits && !stop2v;
      exp_q.push_back(e);
    end
    foreach (q[i]) begin
      rx_in = q[i];
      idle(dv + 1);
    end
    rx_in = 1'b1;
  endtask

  initial begin
    idle(4);
    rst_n = 1'b1;
    enable = 1'b1;
    idle(2);
    chk("reset data_out", {24'd0, data_out}, 32'h0);
    chk("reset busy", {31'd0, busy}, 32'h0);
    chk("reset flags", {29'd0, parity_err, frame_err, overrun_err}, 32'h0);

    // 8N1 0xA5, held until ack
    send(8'hA5, -1, 1'b1, 1'b1);
    idle(12);
    chk("A5 data", {24'd0, data_out}, 32'hA5);
    chk("A5 held", {31'd0, data_valid}, 32'h1);
    ack_pulse();
    chk("A5 acked valid", {31'd0, data_valid}, 32'h0);
    chk("A5 acked keeps data", {24'd0, data_out}, 32'hA5);

    // 7 data bits, even parity: wrong then right parity bit
    data_bits = 3'd6; parity_config = 2'b10;
    send(8'h55, 1, 1'b1, 1'b1);
    idle(6);
    chk("par bad data", {24'd0, data_out}, 32'h55);
    chk("par bad flag", {31'd0, parity_err}, 32'h1);
    ack_pulse();
    send(8'h55, 0, 1'b1, 1'b1);
    idle(6);
    chk("par good flag", {31'd0, parity_err}, 32'h0);
    ack_pulse();

    // Divisor below floor, 5 bits odd parity (upper bits must read 0)
    baud_divisor = 16'd1; data_bits = 3'd4; parity_config = 2'b01;
    send(8'hF3, -1, 1'b1, 1'b1);
    idle(6);
    chk("odd5 data", {24'd0, data_out}, 32'h13);
    ack_pulse();

    // 8N2 with the second stop low
    baud_divisor = 16'd3; data_bits = 3'd7; parity_config = 2'b00; stop_bits = 1'b1;
    send(8'h0F, -1, 1'b0, 1'b1);
    idle(6);
    chk("8N2 data", {24'd0, data_out}, 32'h0F);
    chk("8N2 frame_err", {31'd0, frame_err}, 32'h1);
    ack_pulse();
    stop_bits = 1'b0;

    // One-clock glitch is rejected
    baud_divisor = 16'd7;
    rx_in = 1'b0;
    idle(1);
    rx_in = 1'b1;
    idle(3);
    chk("glitch busy start", {31'd0, busy}, 32'h1);
    idle(12);
    chk("glitch busy end", {31'd0, busy}, 32'h0);
    chk("glitch no data", {31'd0, data_valid}, 32'h0);

    // Overrun, then ack landing on the completion edge
    baud_divisor = 16'd3;
    send(8'h11, -1, 1'b1, 1'b1);
    send(8'h3C, -1, 1'b1, 1'b1);
    idle(6);
    chk("overrun data", {24'd0, data_out}, 32'h3C);
    chk("overrun flag", {31'd0, overrun_err}, 32'h1);
    fork
      send(8'h77, -1, 1'b1, 1'b1);
      begin
        do idle(1); while (cyc < last_comp - 1);
        data_ack = 1'b1;
        idle(1);
        data_ack = 1'b0;
        chk("ack+done valid", {31'd0, data_valid}, 32'h1);
        chk("ack+done overrun", {31'd0, overrun_err}, 32'h0);
        chk("ack+done data", {24'd0, data_out}, 32'h77);
      end
    join
    idle(4);
    ack_pulse();

    // enable dropped mid-DATA: frame discarded
    fork
      send(8'h5A, -1, 1'b1, 1'b0);
      begin
        idle(10);
        chk("en drop busy before", {31'd0, busy}, 32'h1);
        enable = 1'b0;
        idle(1);
        chk("en drop busy after", {31'd0, busy}, 32'h0);
      end
    join
    idle(6);
    enable = 1'b1;
    idle(2);
    chk("en drop no data", {31'd0, data_valid}, 32'h0);

    // Reset mid-frame (all-ones byte so no edges follow the reset)
    send(8'h81, -1, 1'b1, 1'b1);
    idle(6);
    fork
      send(8'hFF, -1, 1'b1, 1'b0);
      begin
        idle(10);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
    join
    idle(6);
    chk("post rst data_out", {24'd0, data_out}, 32'h0);
    chk("post rst valid", {31'd0, data_valid}, 32'h0);
    chk("post rst busy", {31'd0, busy}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

endmodule
